// File: rtl/knn_seq_if.sv
// rtl/knn_seq_if.sv - Query/stream/result bus for the k-nearest-neighbour search block
// master drives queries and points and consumes results; slave is the search block.
interface knn_seq_if #(
  parameter int W = 32,
  parameter int K = 2,
  parameter int N = 16
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic              start;
  logic [W-1:0]      query;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [W*K-1:0]    out_data;
  logic [IW*K-1:0]   out_idx;
  logic              busy;

  modport master (
    output start, query, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, busy
  );

  modport slave (
    input  start, query, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, busy
  );
endinterface

// File: rtl/knn_seq.sv
// rtl/knn_seq.sv - Streaming K-nearest-neighbour search over N points per query
// Keeps a sorted list of K slots; each accepted point is inserted in one cycle.
module knn_seq #(
  parameter int W = 32,
  parameter int K = 2,
  parameter int N = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  knn_seq_if.slave   bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state;
  logic [W-1:0]    q_reg;
  logic [IW-1:0]   cnt;
  logic            rdy_r;
  logic            ov_r;
  logic            busy_r;

  logic [W-1:0]    s_dist [K];
  logic [W-1:0]    s_val  [K];
  logic [IW-1:0]   s_idx  [K];
  logic [K-1:0]    s_vld;

  logic [W-1:0]    n_dist [K];
  logic [W-1:0]    n_val  [K];
  logic [IW-1:0]   n_idx  [K];
  logic [K-1:0]    n_vld;

  logic [W-1:0]    d;
  logic [K-1:0]    better;
  logic [K:0]      prev_better;
  logic            last;

  assign d    = (bus.in_data >= q_reg) ? (bus.in_data - q_reg) : (q_reg - bus.in_data);
  assign last = (cnt == IW'(N - 1));

  // better[] is monotone because valid slots stay packed and sorted; the first
  // set bit is the insertion point, everything above it shifts up by one.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      better[i] = !s_vld[i] || (s_dist[i] > d);
    end
    prev_better = {better, 1'b0};
    for (int i = 0; i < K; i++) begin
      int j;
      j         = (i > 0) ? (i - 1) : 0;
      n_dist[i] = s_dist[i];
      n_val[i]  = s_val[i];
      n_idx[i]  = s_idx[i];
      n_vld[i]  = s_vld[i];
      if (better[i]) begin
        if (!prev_better[i]) begin
          n_dist[i] = d;
          n_val[i]  = bus.in_data;
          n_idx[i]  = cnt;
          n_vld[i]  = 1'b1;
        end else begin
          n_dist[i] = s_dist[j];
          n_val[i]  = s_val[j];
          n_idx[i]  = s_idx[j];
          n_vld[i]  = s_vld[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q_reg  <= '0;
      cnt    <= '0;
      rdy_r  <= 1'b0;
      ov_r   <= 1'b0;
      busy_r <= 1'b0;
      s_vld  <= '0;
      for (int i = 0; i < K; i++) begin
        s_dist[i] <= '0;
        s_val[i]  <= '0;
        s_idx[i]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            q_reg  <= bus.query;
            cnt    <= '0;
            s_vld  <= '0;
            rdy_r  <= 1'b1;
            busy_r <= 1'b1;
            state  <= STREAM;
          end
        end
        STREAM: begin
          if (bus.in_valid) begin
            s_vld <= n_vld;
            for (int i = 0; i < K; i++) begin
              s_dist[i] <= n_dist[i];
              s_val[i]  <= n_val[i];
              s_idx[i]  <= n_idx[i];
            end
            if (last) begin
              rdy_r <= 1'b0;
              ov_r  <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + IW'(1);
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_r   <= 1'b0;
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = rdy_r;
  assign bus.out_valid = ov_r;
  assign bus.busy      = busy_r;

  for (genvar g = 0; g < K; g++) begin : g_pack
    assign bus.out_data[g*W +: W]   = s_val[g];
    assign bus.out_idx[g*IW +: IW]  = s_idx[g];
  end
endmodule

// File: tb/tb_knn_seq.sv
// tb/tb_knn_seq.sv - Scoreboard bench for knn_seq (W=8, K=2, N=4)
// Expected results come from a sort-by-distance reference model.
module tb_knn_seq;
  localparam int W  = 8;
  localparam int K  = 2;
  localparam int N  = 4;
  localparam int IW = 2;

  typedef logic [W-1:0] pts_t [N];
  typedef struct {
    logic [W*K-1:0]  data;
    logic [IW*K-1:0] idx;
  } exp_t;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   tot_cnt;
  exp_t sb[$];

  knn_seq_if #(.W(W), .K(K), .N(N)) bif ();
  knn_seq #(.W(W), .K(K), .N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Pick the K smallest distances; on equal distance the lower arrival index wins.
  function automatic exp_t model(input logic [W-1:0] q, input pts_t pts);
    exp_t e;
    bit   used [N];
    e.data = '0;
    e.idx  = '0;
    for (int j = 0; j < N; j++) used[j] = 1'b0;
    for (int s = 0; s < K; s++) begin
      int best, bd;
      best = -1;
      bd   = 0;
      for (int j = 0; j < N; j++) begin
        int dj;
        dj = int'(pts[j]) - int'(q);
        if (dj < 0) dj = -dj;
        if (!used[j] && (best < 0 || dj < bd)) begin
          best = j;
          bd   = dj;
        end
      end
      used[best] = 1'b1;
      e.data[s*W +: W]  = pts[best];
      e.idx[s*IW +: IW] = IW'(best);
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'(bif.out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_data", 32'(bif.out_data), 32'(e.data));
        check("out_idx", 32'(bif.out_idx), 32'(e.idx));
      end
    end
  end

  task automatic run_query(input logic [W-1:0] q, input pts_t pts, input bit gaps,
                           input int bp, input bit ign);
    exp_t e;
    e = model(q, pts);
    bif.start = 1'b1;
    bif.query = q;
    @(posedge clk); #1;
    bif.start = 1'b0;
    bif.query = W'($urandom);
    check("busy_stream", 32'(bif.busy), 32'd1);
    check("in_ready_stream", 32'(bif.in_ready), 32'd1);
    for (int b = 0; b < N; b++) begin
      if (gaps && b > 0) begin
        bif.in_valid = 1'b0;
        bif.in_data  = W'($urandom);
        @(posedge clk); #1;
      end
      bif.in_valid = 1'b1;
      bif.in_data  = pts[b];
      if (ign && b == 1) begin
        bif.start = 1'b1;
        bif.query = '0;
      end
      if (b == N - 1) sb.push_back(e);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
      bif.start    = 1'b0;
      if (b < N - 1) check("no_early_valid", 32'(bif.out_valid), 32'd0);
    end
    check("out_valid_latency", 32'(bif.out_valid), 32'd1);
    check("in_ready_done", 32'(bif.in_ready), 32'd0);
    for (int c = 0; c < bp; c++) begin
      check("hold_stable", 32'(bif.out_data), 32'(e.data));
      bif.in_valid = 1'b1;
      bif.in_data  = W'($urandom);
      @(posedge clk); #1;
      bif.in_valid = 1'b0;
    end
    bif.out_ready = 1'b1;
    bif.start     = ign;
    @(posedge clk); #1;
    bif.out_ready = 1'b0;
    bif.start     = 1'b0;
    check("busy_idle", 32'(bif.busy), 32'd0);
    check("out_valid_idle", 32'(bif.out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    pts_t p;
    pass_cnt      = 0;
    tot_cnt       = 0;
    rst_n         = 1'b0;
    bif.start     = 1'b0;
    bif.query     = '0;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_out_valid", 32'(bif.out_valid), 32'd0);
    check("rst_in_ready", 32'(bif.in_ready), 32'd0);
    rst_n = 1'b1;

    p = '{8'd10, 8'd48, 8'd90, 8'd53};   run_query(8'd50, p, 1'b0, 0, 1'b0);
    p = '{8'd95, 8'd105, 8'd200, 8'd0};  run_query(8'd100, p, 1'b0, 0, 1'b0);
    p = '{8'd10, 8'd48, 8'd90, 8'd53};   run_query(8'd50, p, 1'b1, 5, 1'b0);
    p = '{8'd255, 8'd255, 8'd1, 8'd0};   run_query(8'd0, p, 1'b0, 1, 1'b0);
    p = '{8'd60, 8'd200, 8'd45, 8'd70};  run_query(8'd50, p, 1'b0, 2, 1'b1);

    bif.start = 1'b1;
    bif.query = 8'd50;
    @(posedge clk); #1;
    bif.start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bif.in_valid = 1'b1;
      bif.in_data  = 8'd51 + 8'(b);
      @(posedge clk); #1;
    end
    bif.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bif.busy), 32'd0);
    check("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    p = '{8'd7, 8'd9, 8'd1, 8'd30};      run_query(8'd7, p, 1'b0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      for (int j = 0; j < N; j++) p[j] = W'($urandom);
      if (t % 5 == 0) p[2] = p[0];
      run_query(W'($urandom), p, 1'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
